// File: rtl/vga_timing_pkg.sv
// Shared timing constants, axis phase encoding and sync-polarity values for the VGA timing generator.
// The optional colour-bar generator in the top level is enabled by defining VGA_TEST_PATTERN_EN.
package vga_timing_pkg;

   localparam int unsigned CNT_W = 10;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_PIPE_DLY = 2;

   localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } phase_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank;
   } align_t;

   function automatic phase_t phase_of(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] fp_start,
                                       input logic [CNT_W-1:0] sync_start,
                                       input logic [CNT_W-1:0] bp_start);
      if (cnt < fp_start)   return PH_ACTIVE;
      if (cnt < sync_start) return PH_FP;
      if (cnt < bp_start)   return PH_SYNC;
      return PH_BP;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter with its ACTIVE/FP/SYNC/BP phase decode.
// Resets to the last back-porch count so the first enabled edge lands on position 0.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output phase_t           phase,
   output logic             wrap
);

   localparam int unsigned      TOTAL      = ACTIVE + FP + SYNC + BP;
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE + FP + SYNC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= LAST;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign wrap  = en && (cnt == LAST);
   assign phase = phase_of(cnt, FP_START, SYNC_START, BP_START);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: pixel coordinates out to the renderer, sync/blank re-aligned to its latency.
// Define VGA_TEST_PATTERN_EN to add a 64-px colour-bar source selected by test_pattern.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned PIPE_DLY = DEF_PIPE_DLY,
   parameter bit          SYNC_POL = SYNC_ACTIVE_LOW
)
(
   input  logic       vga_clk,
   input  logic       arst_n,
   input  logic [3:0] red_in,
   input  logic [3:0] green_in,
   input  logic [3:0] blue_in,
   input  logic       test_pattern,
   output logic [9:0] col,
   output logic [8:0] row,
   output logic       active,
   output logic       frame_start,
   output logic       line_start,
   output logic       hsync,
   output logic       vsync,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue
);

   localparam logic   SYNC_IDLE  = ~SYNC_POL;
   localparam align_t ALIGN_IDLE = '{hsync: SYNC_IDLE, vsync: SYNC_IDLE, blank: 1'b1};

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   phase_t           h_phase;
   phase_t           v_phase;
   logic             h_wrap;
   logic             v_wrap_unused;
   logic             h_vis;
   logic             v_vis;
   align_t           raw;
   align_t           dly;
   logic [11:0]      rgb_sel;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk   (vga_clk),
      .rst_n (arst_n),
      .en    (1'b1),
      .cnt   (h_cnt),
      .phase (h_phase),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk   (vga_clk),
      .rst_n (arst_n),
      .en    (h_wrap),
      .cnt   (v_cnt),
      .phase (v_phase),
      .wrap  (v_wrap_unused)
   );

   assign h_vis       = (h_phase == PH_ACTIVE);
   assign v_vis       = (v_phase == PH_ACTIVE);
   assign active      = h_vis && v_vis;
   assign col         = h_vis ? h_cnt : '0;
   assign row         = v_vis ? v_cnt[8:0] : '0;
   assign frame_start = (h_cnt == '0) && (v_cnt == '0);
   assign line_start  = (h_cnt == '0) && v_vis;

   assign raw = '{hsync: (h_phase == PH_SYNC) ^ SYNC_IDLE,
                  vsync: (v_phase == PH_SYNC) ^ SYNC_IDLE,
                  blank: ~active};

   // Delay line matches the renderer latency; it resets full of blank/idle-sync so no partial pulse escapes.
   generate
      if (PIPE_DLY == 0) begin : g_no_dly
         assign dly = raw;
      end else begin : g_dly
         align_t sr [PIPE_DLY];
         always_ff @(posedge vga_clk or negedge arst_n) begin
            if (!arst_n) begin
               for (int unsigned i = 0; i < PIPE_DLY; i++) sr[i] <= ALIGN_IDLE;
            end else begin
               sr[0] <= raw;
               for (int unsigned i = 1; i < PIPE_DLY; i++) sr[i] <= sr[i-1];
            end
         end
         assign dly = sr[PIPE_DLY-1];
      end
   endgenerate

`ifdef VGA_TEST_PATTERN_EN
   logic [11:0] pat_raw;
   logic [11:0] pat_dly;

   assign pat_raw = {{4{col[6]}}, {4{col[7]}}, {4{col[8]}}};

   generate
      if (PIPE_DLY == 0) begin : g_pat_no_dly
         assign pat_dly = pat_raw;
      end else begin : g_pat_dly
         logic [11:0] pat_sr [PIPE_DLY];
         always_ff @(posedge vga_clk or negedge arst_n) begin
            if (!arst_n) begin
               for (int unsigned i = 0; i < PIPE_DLY; i++) pat_sr[i] <= '0;
            end else begin
               pat_sr[0] <= pat_raw;
               for (int unsigned i = 1; i < PIPE_DLY; i++) pat_sr[i] <= pat_sr[i-1];
            end
         end
         assign pat_dly = pat_sr[PIPE_DLY-1];
      end
   endgenerate

   assign rgb_sel = test_pattern ? pat_dly : {red_in, green_in, blue_in};
`else
   logic unused_test_pattern;
   assign unused_test_pattern = test_pattern;
   assign rgb_sel = {red_in, green_in, blue_in};
`endif

   always_ff @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
         hsync               <= SYNC_IDLE;
         vsync               <= SYNC_IDLE;
         {red, green, blue}  <= '0;
      end else begin
         hsync               <= dly.hsync;
         vsync               <= dly.vsync;
         {red, green, blue}  <= dly.blank ? '0 : rgb_sel;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a reduced raster, checked every cycle against a position-arithmetic model.
// Honours VGA_TEST_PATTERN_EN the same way the design does.
module tb_vga_timing_gen;

   localparam int HA = 200, HF = 8, HS = 12, HB = 10;
   localparam int VA = 12,  VF = 2, VS = 3,  VB = 4;
   localparam int PD = 2;
   localparam int HT = HA + HF + HS + HB;   // 230
   localparam int VT = VA + VF + VS + VB;   // 21
   localparam int FRAME = HT * VT;          // 4830

   logic       vga_clk = 1'b0;
   logic       arst_n  = 1'b1;
   logic [3:0] red_in = '0, green_in = '0, blue_in = '0;
   logic       test_pattern = 1'b0;
   logic [9:0] col;
   logic [8:0] row;
   logic       active, frame_start, line_start, hsync, vsync;
   logic [3:0] red, green, blue;

   vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .PIPE_DLY (PD), .SYNC_POL (1'b0)
   ) dut (
      .vga_clk      (vga_clk),
      .arst_n       (arst_n),
      .red_in       (red_in),
      .green_in     (green_in),
      .blue_in      (blue_in),
      .test_pattern (test_pattern),
      .col          (col),
      .row          (row),
      .active       (active),
      .frame_start  (frame_start),
      .line_start   (line_start),
      .hsync        (hsync),
      .vsync        (vsync),
      .red          (red),
      .green        (green),
      .blue         (blue)
   );

   always #20 vga_clk = ~vga_clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Raster position (linear pixel index) after e clock edges since reset release.
   function automatic int pos_of(input int e);
      return (e + FRAME - 1) % FRAME;
   endfunction

   // Model state: edge count since release, plus the inputs latched at the latest edge.
   int          edges = 0;
   int          epoch = 0;
   logic [11:0] cur_rgb = '0;
   logic        cur_tp  = 1'b0;

   always @(posedge vga_clk or negedge arst_n) begin
      if (!arst_n) begin
         edges = 0;
         epoch++;
      end else begin
         edges++;
         cur_rgb = {red_in, green_in, blue_in};
         cur_tp  = test_pattern;
      end
   end

   bit   col_chk = 0;
   int   seen_epoch = 0;
   logic prev_hs = 1'b1, prev_vs = 1'b1;
   int   hs_run = 0, vs_run = 0;
   bit   hs_valid = 0, vs_valid = 0;
   int   last_fs = -1;

   always @(negedge vga_clk) begin : cmp
      int p, h, v, s, ps, sh, sv, c;
      logic blank, ehs, evs;
      logic [11:0] ergb;
      logic [21:0] ecoord;
      if (epoch != seen_epoch) begin
         seen_epoch = epoch;
         hs_valid = 0;
         vs_valid = 0;
         last_fs = -1;
      end
      p = pos_of(edges);
      h = p % HT;
      v = p / HT;
      ecoord = {10'((h < HA) ? h : 0), 9'((v < VA) ? v : 0),
                (h < HA) && (v < VA), p == 0, (h == 0) && (v < VA)};
      check("coords{col,row,active,frame_start,line_start}",
            {col, row, active, frame_start, line_start}, ecoord);

      s = edges - 1 - PD;
      if (s < 0) begin
         blank = 1'b1; ehs = 1'b1; evs = 1'b1; sh = HT - 1; sv = VT - 1;
      end else begin
         ps = pos_of(s);
         sh = ps % HT;
         sv = ps / HT;
         blank = !((sh < HA) && (sv < VA));
         ehs = !((sh >= HA + HF) && (sh < HA + HF + HS));
         evs = !((sv >= VA + VF) && (sv < VA + VF + VS));
      end
      ergb = cur_rgb;
`ifdef VGA_TEST_PATTERN_EN
      if (cur_tp) begin
         c = (sh < HA) ? sh : 0;
         ergb = {((c / 64) % 2 == 1) ? 4'hF : 4'h0,
                 ((c / 128) % 2 == 1) ? 4'hF : 4'h0,
                 ((c / 256) % 2 == 1) ? 4'hF : 4'h0};
      end
      if (cur_tp && s >= 0 && sv < VA && sh == 64)  check("bar_col64",  {red, green, blue}, 12'hF00);
      if (cur_tp && s >= 0 && sv < VA && sh == 128) check("bar_col128", {red, green, blue}, 12'h0F0);
`endif
      if (blank) ergb = '0;
      check("pins{hsync,vsync,rgb}", {hsync, vsync, red, green, blue}, {ehs, evs, ergb});

      if (col_chk && s >= 0 && sv < VA && sh == 0)  check("red_first_px", red, 4'h0);
      if (col_chk && s >= 0 && sv < VA && sh == 15) check("red_px15",     red, 4'hF);

      if (frame_start) begin
         if (last_fs >= 0) check("frame_period", edges - last_fs, 4830);
         last_fs = edges;
      end

      // Pin sync lags the raw phase by PIPE_DLY+1: hsync falls at h=208+3, vsync at (h=3, line 14).
      if (!hsync) begin
         if (prev_hs) begin
            check("hsync_fall_h", h, 211);
            hs_run = 1;
            hs_valid = 1;
         end else hs_run++;
      end else if (!prev_hs && hs_valid) begin
         check("hsync_low_cycles", hs_run, 12);
         hs_valid = 0;
      end
      if (!vsync) begin
         if (prev_vs) begin
            check("vsync_fall_line", v, 14);
            check("vsync_fall_h", h, 3);
            vs_run = 1;
            vs_valid = 1;
         end else vs_run++;
      end else if (!prev_vs && vs_valid) begin
         check("vsync_low_cycles", vs_run, 690);
         vs_valid = 0;
      end
      prev_hs = hsync;
      prev_vs = vsync;
   end

   logic [9:0] colq[$];

   // mode 0: random colour and test_pattern; 1: red_in = col delayed PD cycles; 2: constant white
   task automatic drive(input int mode);
      logic [9:0] old_col;
      case (mode)
         1: begin
            colq.push_back(col);
            if (colq.size() > PD + 1) void'(colq.pop_front());
            old_col = colq[0];
            red_in = (colq.size() == PD + 1) ? old_col[3:0] : 4'h0;
            green_in = 4'($urandom);
            blue_in = 4'($urandom);
            test_pattern = 1'b0;
         end
         2: begin
            red_in = 4'hF; green_in = 4'hF; blue_in = 4'hF;
            test_pattern = 1'b0;
         end
         default: begin
            red_in = 4'($urandom);
            green_in = 4'($urandom);
            blue_in = 4'($urandom);
            test_pattern = 1'($urandom_range(0, 1));
         end
      endcase
   endtask

   task automatic run(input int mode, input int n);
      repeat (n) begin
         drive(mode);
         @(posedge vga_clk);
         #2;
      end
   endtask

   initial begin
      bit reached;
      #1 arst_n = 1'b0;
      repeat (4) @(posedge vga_clk);
      #2;
      check("rst_sync", {hsync, vsync}, 2'b11);
      check("rst_rgb", {red, green, blue}, 12'h000);
      check("rst_coords", {col, row, active, frame_start, line_start}, 22'h0);

      arst_n = 1'b1;
      @(posedge vga_clk);
      #1;
      check("first_frame_start", frame_start, 1'b1);
      check("first_col_row", {col, row}, 19'h0);
      check("first_active", active, 1'b1);
      #1;

      colq.delete();
      run(1, PD + 2);
      col_chk = 1;
      run(1, 2 * FRAME);
      col_chk = 0;
      run(2, FRAME + 50);
      run(0, FRAME);

      reached = 0;
      for (int i = 0; i < FRAME + 2; i++) begin
         if (pos_of(edges) % HT == 100 && pos_of(edges) / HT == 5) begin
            reached = 1;
            break;
         end
         run(2, 1);
      end
      check("reset_target_reached", reached, 1'b1);
      #3 arst_n = 1'b0;
      #1;
      check("async_rst_coords", {col, row, active}, 20'h0);
      check("async_rst_rgb", {red, green, blue}, 12'h000);
      check("async_rst_sync", {hsync, vsync}, 2'b11);
      repeat (3) @(posedge vga_clk);
      #2 arst_n = 1'b1;
      @(posedge vga_clk);
      #1;
      check("restart_frame_start", frame_start, 1'b1);
      #1;

      repeat (4) begin
         run(0, $urandom_range(200, 3000));
         #3 arst_n = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge vga_clk);
         #2 arst_n = 1'b1;
      end
      run(0, FRAME + 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: run exceeded time limit, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock. Supplies `col`/`row` coordinates to the game/demo stage and accepts its 12-bit RGB back. Re-aligns sync and blanking to that stage's pipeline latency, then drives the VGA pins. Sits directly upstream, for coordinates, and downstream, for colour, of the sprite/labyrinth renderer.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch
- `PIPE_DLY`, 2, cycles from `col`/`row` to valid `red_in`/`green_in`/`blue_in`; range 0..7
- `SYNC_POL`, 0, sync polarity: 0 means active-low pulses

Ports:
- `vga_clk`  in  1  pixel clock, 25 MHz; the only clock
- `arst_n`  in  1  reset; asynchronous and active-low
- `red_in`, `green_in`, `blue_in`  in  4 each  colour from the renderer
- `test_pattern`  in  1  selects the colour bars (see Configuration)
- `col`  out  10  pixel column, 0..639
- `row`  out  9  pixel row, 0..479
- `active`  out  1  current counter position is visible
- `frame_start`  out  1  one-cycle pulse at (0,0)
- `line_start`  out  1  one-cycle pulse at h=0 of every visible line
- `hsync`, `vsync`  out  1 each  VGA sync, delayed and registered
- `red`, `green`, `blue`  out  4 each  VGA colour, delayed and registered

## Operation
Counters:
- `h_cnt` runs 0..H_TOTAL-1, with H_TOTAL = 800. At H_TOTAL-1 it wraps to 0 and increments `v_cnt`.
- `v_cnt` runs 0..V_TOTAL-1, with V_TOTAL = 525, and wraps to 0.
- Both counters are 10 bits wide.

Phase per axis:
- PH_ACTIVE: cnt < ACTIVE
- PH_FP: next FP counts
- PH_SYNC: next SYNC counts
- PH_BP: remaining counts
- Transitions are strictly cyclic: ACTIVE → FP → SYNC → BP → ACTIVE.

Decoded outputs (combinational from the counter registers):
- `active` = (h phase ACTIVE) & (v phase ACTIVE).
- `col` = `h_cnt` when h is ACTIVE, else 0.
- `row` = `v_cnt[8:0]` when v is ACTIVE, else 0.
- `frame_start` = (`h_cnt` == 0 & `v_cnt` == 0).
- `line_start` = (`h_cnt` == 0 & v ACTIVE).

Alignment pipeline:
- Raw sync is PH_SYNC for each axis, XOR'd with !SYNC_POL.
- Raw sync and blank (!`active`) pass through a PIPE_DLY-deep shift register.
- Output register: `hsync`/`vsync` take the delayed sync values. `red`/`green`/`blue` take 0 when delayed blank is set, else the selected colour.
- PIPE_DLY = 0 means the shift register is omitted.
- Colour is forced to 0 in blanking regardless of the inputs.

## Timing
- Reset values:
  - `h_cnt` = 799, `v_cnt` = 524 (the last BP position).
  - Therefore `col` = 0, `row` = 0, `active` = 0, `frame_start` = 0, `line_start` = 0.
  - `hsync`/`vsync` inactive (1 for SYNC_POL = 0); RGB = 0.
  - The delay line is filled with blank = 1 and sync inactive.
- First edge after reset release: counters go to (0,0) and `frame_start` = 1.
- Latency: an input (`col`, `row`) at cycle N is shown on the pins at cycle N+PIPE_DLY+1, together with its sync and blank.
- Reset asserted mid-frame: everything returns to reset values immediately. The frame restarts cleanly on release, with no partial sync pulse.
- Wrap cases:
  - h = 799 → 0 and v = 524 → 0 happen on the same edge; `frame_start` follows.
  - `line_start` is not asserted on vertical blanking lines.
- Sync widths: hsync is 96 cycles low per line; vsync is 2 lines (1600 cycles) low per frame.

## Configuration
- `VGA_TEST_PATTERN_EN` defined:
  - Adds a colour-bar generator: R = {4{col[6]}}, G = {4{col[7]}}, B = {4{col[8]}}, giving 64-px bars.
  - The pattern is delayed PIPE_DLY cycles with the syncs.
  - When `test_pattern` = 1 the pattern replaces `red_in`/`green_in`/`blue_in`.
- Undefined: the generator is absent, `test_pattern` is ignored and the colour inputs are always used.

## Structure
- Package `vga_timing_pkg`:
  - Default timing constants and H_TOTAL/V_TOTAL.
  - Phase enum PH_ACTIVE/PH_FP/PH_SYNC/PH_BP, 2 bits.
  - Sync-polarity constants.
- Sub-module `vga_axis_counter`:
  - Parameterised by ACTIVE/FP/SYNC/BP.
  - Ports: `en` input; `cnt`, `phase` and `wrap` outputs.
  - Instantiated twice. The horizontal instance has `en` = 1; the vertical instance has `en` = horizontal `wrap`.

## Test plan
- Reset, then release → `frame_start` high on the first cycle only, with (`col`,`row`) = (0,0), `active` = 1, `hsync` = `vsync` = 1 during reset.
- Free-run one frame → 420000 cycles between `frame_start` pulses. hsync falls at h = 656 + PIPE_DLY + 1 and stays low for 96 cycles. vsync is low for lines 490..491.
- Drive `red_in` = `col[3:0]`, delayed PIPE_DLY = 2 → pin `red` at the first visible pixel of a line = 0 and at pixel 15 = 4'hF. `red` = 0 for all blanked pixels.
- Constant colour 12'hFFF → RGB = 0 from h = 640..799 and on lines 480..524.
- Assert `arst_n` at h = 300, v = 200 for 3 cycles → outputs return to reset values asynchronously. `frame_start` occurs 1 cycle after release.
- With `VGA_TEST_PATTERN_EN` and `test_pattern` = 1 → `col` = 64 gives R = F, G = 0, B = 0; `col` = 448 gives R = F, G = F, B = F. Without the macro, `test_pattern` has no effect.
